// File: rtl/sync_sram_pkg.sv
// Shared types and constants for the sync_sram block: FSM encoding and the
// default fill byte used by the post-reset clear sweep.
package sync_sram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    localparam logic [7:0] SENTINEL_DEFAULT = 8'h0f;

endpackage

// File: rtl/sync_sram_rdpipe.sv
// Read-latency shift register: LATENCY stages of {valid, data}; stage 0 captures at the accept edge.
// Latency LATENCY clocks from accept to output; no backpressure, reset flushes every stage.
module sync_sram_rdpipe #(
    parameter int LATENCY = 2,
    parameter int DWIDTH  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_vld,
    input  logic [DWIDTH-1:0] in_dat,
    output logic              out_vld,
    output logic [DWIDTH-1:0] out_dat
);

    logic [LATENCY-1:0] vld_q, vld_d;
    logic [DWIDTH-1:0]  dat_q [LATENCY];
    logic [DWIDTH-1:0]  dat_d [LATENCY];

    always_comb begin
        vld_d[0] = in_vld;
        dat_d[0] = in_vld ? in_dat : '0;
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = dat_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int i = 0; i < LATENCY; i++) begin
                dat_q[i] <= dat_d[i];
            end
        end
    end

    // Data is zeroed on entry when invalid, the mask keeps rd clean regardless.
    assign out_vld = vld_q[LATENCY-1];
    assign out_dat = vld_q[LATENCY-1] ? dat_q[LATENCY-1] : '0;

endmodule

// File: rtl/sync_sram.sv
// Single-port synchronous SRAM with byte-lane writes, pipelined reads and an optional post-reset sentinel fill.
// Read data LATENCY clocks after accept; ready is low during the clear sweep and requests then are dropped and flagged in err.
import sync_sram_pkg::*;

module sync_sram #(
    parameter int         BITS           = 10,
    parameter int         DWIDTH         = 16,
    parameter int         LATENCY        = 2,
    parameter bit         CLEAR_ON_RESET = 1'b1,
    parameter logic [7:0] SENTINEL       = SENTINEL_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  we,
    input  logic [BITS-1:0]       a,
    input  logic [DWIDTH/8-1:0]   be,
    input  logic [DWIDTH-1:0]     wd,
    output logic                  ready,
    output logic                  rvalid,
    output logic [DWIDTH-1:0]     rd,
    output logic                  busy,
    output logic                  err
);

    localparam int             LANES     = DWIDTH / 8;
    localparam int             DEPTH     = 2 ** BITS;
    localparam state_e         RST_STATE = CLEAR_ON_RESET ? CLEAR : RUN;
    localparam logic [DWIDTH-1:0] FILL   = {LANES{SENTINEL}};

    logic [DWIDTH-1:0] mem [DEPTH];

    state_e            state_q, state_d;
    logic [BITS-1:0]   cnt_q, cnt_d;
    logic              err_q, err_d;

    logic              wr_en;
    logic [BITS-1:0]   wr_addr;
    logic [LANES-1:0]  wr_be;
    logic [DWIDTH-1:0] wr_dat;
    logic              rd_en;
    logic [DWIDTH-1:0] rd_raw;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        wr_addr = a;
        wr_be   = be;
        wr_dat  = wd;
        rd_en   = 1'b0;
        busy    = (state_q == CLEAR);
        ready   = (state_q == RUN);
        err_d   = err_q | (req & ~ready);

        case (state_q)
            CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = cnt_q;
                wr_be   = '1;
                wr_dat  = FILL;
                // Counter parks on the last word; the state change ends the sweep.
                if (cnt_q == '1) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + BITS'(1);
                end
            end
            RUN: begin
                wr_en = req & we;
                rd_en = req & ~we;
            end
            default: state_d = RST_STATE;
        endcase

        // Nothing issued while reset is held may touch memory or the read pipe.
        if (reset) begin
            wr_en = 1'b0;
            rd_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][8*i +: 8] <= wr_dat[8*i +: 8];
                end
            end
        end
    end

    assign rd_raw = rd_en ? mem[a] : '0;

    sync_sram_rdpipe #(
        .LATENCY (LATENCY),
        .DWIDTH  (DWIDTH)
    ) u_rdpipe (
        .clk     (clk),
        .reset   (reset),
        .in_vld  (rd_en),
        .in_dat  (rd_raw),
        .out_vld (rvalid),
        .out_dat (rd)
    );

    assign err = err_q;

endmodule
